poly8_sdiv_32s_16s_32_seq: RTL

Iterative signed divider for the poly8 datapath; the inverse of the 16s x 16s -> 32 product multiplier. Divides a 32-bit signed dividend (typically a product term) by a 16-bit signed divisor, returning a 32-bit quotient and a 16-bit remainder with C truncation semantics. Uses a radix-2 restoring algorithm, one quotient bit per enabled cycle, with a start/done handshake for the HLS controller.

---
 rtl/poly8_sdiv_32s_16s_32_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/poly8_sdiv_32s_16s_32_seq.sv
// Iterative radix-2 restoring signed divider, 32s / 16s -> 32s quotient, 16s remainder.
// C truncation semantics; one quotient bit per enabled cycle behind a start/done handshake.
module poly8_sdiv_32s_16s_32_seq #(
    parameter int unsigned ID         = 1,
    parameter int unsigned DIVIDEND_W = 32,
    parameter int unsigned DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend0,
    input  logic [DIVISOR_W-1:0]  divisor0,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
);

    if (DIVIDEND_W != 32 || DIVISOR_W != 16) begin : g_bad_cfg
        $error("poly8_sdiv instance %0d: only 32/16 widths are supported", ID);
    end

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic        dz_q, dz_d;
    logic [15:0] lo_q, lo_d;
    // dvd_q starts as |dividend| and fills with quotient bits from the right.
    logic [31:0] dvd_q, dvd_d;
    logic [15:0] dvs_q, dvs_d;
    logic [15:0] rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] quot_q, quot_d;
    logic [15:0] rmd_q, rmd_d;

    logic [16:0] rem_shift;
    logic [16:0] rem_sub;
    logic        q_bit;
    logic [31:0] q_fix;
    logic [15:0] r_fix;

    always_comb begin
        // Borrow out of the 17-bit trial subtraction decides the quotient bit.
        rem_shift = {rem_q, dvd_q[31]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_sub[16];

        q_fix = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
        r_fix = sa_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        lo_d    = lo_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = done_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;

        if (ce) begin
            unique case (state_q)
                StIdle: begin
                    done_d = 1'b0;
                    // The done cycle itself sits in idle; it must not launch.
                    if (start && !done_q) begin
                        sa_d    = dividend0[31];
                        sb_d    = divisor0[15];
                        dz_d    = (divisor0 == 16'd0);
                        lo_d    = dividend0[15:0];
                        dvd_d   = dividend0[31] ? -dividend0 : dividend0;
                        dvs_d   = divisor0[15] ? -divisor0 : divisor0;
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    rem_d = q_bit ? rem_sub[15:0] : rem_shift[15:0];
                    dvd_d = {dvd_q[30:0], q_bit};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    if (dz_q) begin
                        quot_d = 32'hFFFF_FFFF;
                        rmd_d  = lo_q;
                    end else begin
                        quot_d = q_fix;
                        rmd_d  = r_fix;
                    end
                    state_d = StDone;
                end
                StDone: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
            lo_q    <= lo_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rmd_q;

endmodule
